dff_en_rr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer sharing one W-bit enabled-D storage register among N requesters.
- Each cycle, selects at most one requester, drives the shared register's en/d from that requester, and reports owner and write acknowledge.
- Supports locked bursts: a requester can keep ownership for up to MAX_HOLD consecutive writes.
- Sits between requesting datapath blocks and the shared register bank built from enabled D flip-flops.

---
 rtl/dff_en_rr_arbiter_pkg.sv | 38 +++
 rtl/dff_en_rr_arbiter_if.sv | 31 +++
 rtl/dff_en_rr_arbiter_register_en.sv | 17 +
 rtl/dff_en_rr_arbiter.sv | 126 ++++++++++++
 tb/tb_dff_en_rr_arbiter.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/dff_en_rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter in front of the shared enabled-D register.
// Provides the FSM state type and the wrapping first-set search.
package dff_en_rr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    localparam int unsigned MAX_REQ = 8;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;

    // First set bit of req at or above ptr, wrapping at n back to 0.
    function automatic rr_pick_t rr_first(input logic [MAX_REQ-1:0] req,
                                          input logic [2:0]         ptr,
                                          input int unsigned        n);
        rr_pick_t    pick;
        int unsigned pos;
        pick = '0;
        pos  = 0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            if (!pick.found && k < n) begin
                pos = 32'(ptr) + k;
                if (pos >= n) pos = pos - n;
                if (req[pos[2:0]]) begin
                    pick.found = 1'b1;
                    pick.idx   = pos[2:0];
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/dff_en_rr_arbiter_if.sv
// Requester-side bus of the shared-register arbiter.
// Optional wr_cnt member exists only when DFF_ARB_WRCNT_EN is defined.
interface dff_en_rr_arbiter_if #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8
);
    localparam int unsigned IW = $clog2(N);

    logic [N-1:0]   req;
    logic [N-1:0]   lock;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   gnt;
    logic [W-1:0]   q;
    logic [IW-1:0]  owner;
    logic           wr_ack;
    logic           locked;
`ifdef DFF_ARB_WRCNT_EN
    logic [15:0]    wr_cnt;

    modport master (output req, lock, wdata,
                    input  gnt, q, owner, wr_ack, locked, wr_cnt);
    modport slave  (input  req, lock, wdata,
                    output gnt, q, owner, wr_ack, locked, wr_cnt);
`else
    modport master (output req, lock, wdata,
                    input  gnt, q, owner, wr_ack, locked);
    modport slave  (input  req, lock, wdata,
                    output gnt, q, owner, wr_ack, locked);
`endif

endinterface

// File: rtl/dff_en_rr_arbiter_register_en.sv
// W-bit enabled D register used as the arbitrated shared storage.
module dff_en_rr_arbiter_register_en #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)   q <= '0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/dff_en_rr_arbiter.sv
// Round-robin arbiter with locked bursts sharing one enabled-D register among N requesters.
// Build option DFF_ARB_WRCNT_EN adds a 16-bit wrapping write counter on the bus.
module dff_en_rr_arbiter
    import dff_en_rr_arbiter_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned W        = 8,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              reset,
    dff_en_rr_arbiter_if.slave bus
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned HW = $clog2(MAX_HOLD + 1);

    arb_state_t          state;
    logic [IW-1:0]       owner_r;
    logic [IW-1:0]       rr_ptr;
    logic [HW-1:0]       hold_cnt;
    logic                wr_ack_r;

    logic [MAX_REQ-1:0]  req_ext;
    rr_pick_t            pick;
    logic                hold_go;
    logic                grant_vld;
    logic [IW-1:0]       grant_idx;
    logic [IW-1:0]       ptr_inc;
    logic [N-1:0]        gnt_c;
    logic [W-1:0]        d_sel;

    always_comb begin
        req_ext        = '0;
        req_ext[N-1:0] = bus.req;
    end

    assign pick    = rr_first(req_ext, 3'(rr_ptr), N);
    assign hold_go = (state == ST_LOCKED) && bus.req[owner_r] && bus.lock[owner_r];

    // A locked owner that lets go falls straight through to RR arbitration this cycle.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = owner_r;
        gnt_c     = '0;
        if (!reset) begin
            if (hold_go) begin
                grant_vld = 1'b1;
                grant_idx = owner_r;
            end else if (pick.found) begin
                grant_vld = 1'b1;
                grant_idx = IW'(pick.idx);
            end
        end
        if (grant_vld) gnt_c[grant_idx] = 1'b1;
    end

    always_comb begin
        d_sel = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (32'(grant_idx) == i) d_sel = bus.wdata[i*W +: W];
        end
    end

    always_comb begin
        if (32'(grant_idx) == N - 1) ptr_inc = '0;
        else                         ptr_inc = grant_idx + IW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            owner_r  <= '0;
            rr_ptr   <= '0;
            hold_cnt <= '0;
            wr_ack_r <= 1'b0;
        end else begin
            wr_ack_r <= grant_vld;
            if (hold_go) begin
                if (32'(hold_cnt) + 1 >= MAX_HOLD) begin
                    state    <= ST_IDLE;
                    hold_cnt <= HW'(MAX_HOLD);
                end else begin
                    hold_cnt <= hold_cnt + HW'(1);
                end
            end else if (grant_vld) begin
                owner_r <= grant_idx;
                rr_ptr  <= ptr_inc;
                if (bus.lock[grant_idx] && MAX_HOLD > 1) begin
                    state    <= ST_LOCKED;
                    hold_cnt <= HW'(1);
                end else begin
                    state    <= ST_IDLE;
                    hold_cnt <= '0;
                end
            end else begin
                state <= ST_IDLE;
            end
        end
    end

`ifdef DFF_ARB_WRCNT_EN
    logic [15:0] wr_cnt_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)          wr_cnt_r <= '0;
        else if (grant_vld) wr_cnt_r <= wr_cnt_r + 16'd1;
    end

    assign bus.wr_cnt = wr_cnt_r;
`endif

    dff_en_rr_arbiter_register_en #(.W(W)) u_store (
        .clk   (clk),
        .reset (reset),
        .en    (|gnt_c),
        .d     (d_sel),
        .q     (bus.q)
    );

    assign bus.gnt    = gnt_c;
    assign bus.owner  = owner_r;
    assign bus.wr_ack = wr_ack_r;
    assign bus.locked = (state == ST_LOCKED);

endmodule

// File: tb/tb_dff_en_rr_arbiter.sv
// Self-checking bench for dff_en_rr_arbiter: directed scenarios plus randomized traffic
// against a behavioural model of the round-robin/burst rules (DFF_ARB_WRCNT_EN aware).
module tb_dff_en_rr_arbiter;

    localparam int N        = 4;
    localparam int W        = 8;
    localparam int MAX_HOLD = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    dff_en_rr_arbiter_if #(.N(N), .W(W)) bus ();

    dff_en_rr_arbiter #(.N(N), .W(W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;

    int          m_ptr, m_lo, m_burst, m_owner;
    logic [W-1:0] m_q;
    logic        m_ack;
    int          m_cnt;
    logic [N-1:0] last_gnt;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_lo = -1; m_burst = 0; m_owner = 0;
        m_q = '0; m_ack = 1'b0; m_cnt = 0;
    endtask

    function automatic bit model_cont();
        return (m_lo >= 0) && bus.req[m_lo] && bus.lock[m_lo];
    endfunction

    // Grantee under the current inputs, -1 when nobody is granted.
    function automatic int model_pick();
        if (model_cont()) return m_lo;
        for (int k = 0; k < N; k++)
            if (bus.req[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic model_edge();
        int g;
        bit cont;
        cont  = model_cont();
        g     = model_pick();
        m_ack = (g >= 0);
        if (g < 0) begin
            m_lo = -1;
        end else begin
            m_q   = bus.wdata[g*W +: W];
            m_cnt = (m_cnt + 1) % 65536;
            if (cont) begin
                m_burst++;
                if (m_burst >= MAX_HOLD) m_lo = -1;
            end else begin
                m_owner = g;
                m_ptr   = (g + 1) % N;
                if (bus.lock[g] && MAX_HOLD > 1) begin
                    m_lo = g; m_burst = 1;
                end else begin
                    m_lo = -1;
                end
            end
        end
    endtask

    // Drive one cycle starting just after a falling edge; returns at the next falling edge.
    task automatic step(input logic [N-1:0] r, input logic [N-1:0] l, input bit rnd);
        int           g;
        logic [N-1:0] eg;
        bus.req  = r;
        bus.lock = l;
        if (rnd) for (int i = 0; i < N; i++) bus.wdata[i*W +: W] = W'($urandom);
        #1;
        g  = model_pick();
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        last_gnt = bus.gnt;
        check_val("gnt", 32'(bus.gnt), 32'(eg));
        model_edge();
        @(posedge clk);
        #1;
        check_val("q",      32'(bus.q),      32'(m_q));
        check_val("owner",  32'(bus.owner),  32'(m_owner));
        check_val("wr_ack", 32'(bus.wr_ack), 32'(m_ack));
        check_val("locked", 32'(bus.locked), 32'(m_lo >= 0));
`ifdef DFF_ARB_WRCNT_EN
        check_val("wr_cnt", 32'(bus.wr_cnt), 32'(m_cnt));
`endif
        @(negedge clk);
    endtask

    initial begin
        logic [N-1:0] r, l;
        int           base;
        model_reset();
        bus.req  = 4'b1111;
        bus.lock = '0;
        for (int i = 0; i < N; i++) bus.wdata[i*W +: W] = W'($urandom);

        #2;
        check_val("rst_gnt", 32'(bus.gnt), 32'h0);
        check_val("rst_q",   32'(bus.q),   32'h0);
        #10;
        check_val("rst_gnt2",   32'(bus.gnt),    32'h0);
        check_val("rst_q2",     32'(bus.q),      32'h0);
        check_val("rst_owner",  32'(bus.owner),  32'h0);
        check_val("rst_ack",    32'(bus.wr_ack), 32'h0);
        check_val("rst_locked", 32'(bus.locked), 32'h0);
        #11;
        reset = 1'b0;

        // Continuous requests rotate 0,1,2,3,0.
        for (int k = 0; k < 5; k++) begin
            step(4'b1111, 4'b0000, 1'b1);
            check_val("rot_gnt", 32'(last_gnt), 32'(1 << (k % N)));
        end

        // Single requester 2 with A5.
        for (int i = 0; i < N; i++) bus.wdata[i*W +: W] = W'($urandom);
        bus.wdata[2*W +: W] = 8'hA5;
        step(4'b0100, 4'b0000, 1'b0);
        check_val("t2_gnt",   32'(last_gnt),   32'h4);
        check_val("t2_q",     32'(bus.q),      32'hA5);
        check_val("t2_owner", 32'(bus.owner),  32'h2);
        check_val("t2_ack",   32'(bus.wr_ack), 32'h1);

        step(4'b1000, 4'b0000, 1'b1);

        // Burst by requester 0 against a waiting requester 3.
        for (int k = 0; k < MAX_HOLD; k++) begin
            step(4'b1001, 4'b0001, 1'b1);
            check_val("burst_gnt", 32'(last_gnt), 32'h1);
        end
        step(4'b1001, 4'b0001, 1'b1);
        check_val("burst_after", 32'(last_gnt), 32'h8);

        // Reset in the middle of requester 2's burst.
        bus.wdata[2*W +: W] = 8'h3C;
        step(4'b0100, 4'b0100, 1'b0);
        check_val("mid_locked", 32'(bus.locked), 32'h1);
        check_val("mid_q",      32'(bus.q),      32'h3C);
        bus.req = '0;
        #1 reset = 1'b1;
        #1;
        check_val("mr_q",      32'(bus.q),      32'h0);
        check_val("mr_locked", 32'(bus.locked), 32'h0);
        check_val("mr_owner",  32'(bus.owner),  32'h0);
        check_val("mr_gnt",    32'(bus.gnt),    32'h0);
        model_reset();
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        check_val("mr_q_hold", 32'(bus.q), 32'h0);
        @(negedge clk);
        step(4'b1111, 4'b0000, 1'b1);
        check_val("mr_restart", 32'(last_gnt), 32'h1);

        // Owner 1 drops lock after two grants; requester 2 is granted that cycle.
        step(4'b0110, 4'b0010, 1'b1);
        step(4'b0110, 4'b0010, 1'b1);
        step(4'b0110, 4'b0000, 1'b1);
        check_val("drop_gnt",    32'(last_gnt),   32'h4);
        check_val("drop_locked", 32'(bus.locked), 32'h0);
        step(4'b0110, 4'b0010, 1'b1);
        step(4'b0110, 4'b0010, 1'b1);
        step(4'b0110, 4'b0100, 1'b1);
        check_val("drop_gnt2",    32'(last_gnt),   32'h4);
        check_val("drop_locked2", 32'(bus.locked), 32'h1);

        // Randomized traffic.
        for (int it = 0; it < 800; it++) begin
            if ($urandom_range(0, 3) == 0) r = N'(1 << $urandom_range(0, N - 1));
            else                           r = N'($urandom);
            if ($urandom_range(0, 3) == 0) l = '0;
            else                           l = N'($urandom);
            step(r, l, 1'b1);
        end

`ifdef DFF_ARB_WRCNT_EN
        base = m_cnt;
        for (int k = 0; k < 10; k++) step(4'b0001, 4'b0000, 1'b1);
        check_val("cnt_10", 32'(bus.wr_cnt), 32'((base + 10) % 65536));
        for (int k = 0; k < 3; k++) step(4'b0000, 4'b0000, 1'b1);
        check_val("cnt_idle", 32'(bus.wr_cnt), 32'((base + 10) % 65536));
        while (m_cnt != 65535) step(4'b0001, 4'b0000, 1'b1);
        step(4'b0010, 4'b0000, 1'b1);
        check_val("cnt_wrap", 32'(bus.wr_cnt), 32'h0);
`else
        base = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
